// File: rtl/polar_extract_seq_if.sv
// Frame-in / result-out handshake bundle for the sequential polar extractor.
// The master drives frames and accepts results; the slave is the extractor itself.
interface polar_extract_seq_if #(
    parameter int LOG_N_MAX = 8,
    parameter int K_MAX     = 128
);
    localparam int N_MAX = 1 << LOG_N_MAX;

    logic                 in_valid;
    logic                 in_ready;
    logic [N_MAX-1:0]     din;
    logic [3:0]           n_log;
    logic [N_MAX-1:0]     info_mask;
    logic                 out_valid;
    logic                 out_ready;
    logic [K_MAX-1:0]     dout;
    logic [LOG_N_MAX:0]   dout_cnt;
    logic                 err_overflow;
    logic                 err_mode;

    modport master (
        output in_valid, din, n_log, info_mask, out_ready,
        input  in_ready, out_valid, dout, dout_cnt, err_overflow, err_mode
    );

    modport slave (
        input  in_valid, din, n_log, info_mask, out_ready,
        output in_ready, out_valid, dout, dout_cnt, err_overflow, err_mode
    );
endinterface

// File: rtl/polar_extract_seq.sv
// Sequential polar re-encode (x = u*F^n, SPC butterfly stages per clock) followed by
// a SCAN_W-wide information-set compaction into a packed K_MAX-bit result.
module polar_extract_seq #(
    parameter int LOG_N_MAX = 8,
    parameter int K_MAX     = 128,
    parameter int SPC       = 2,
    parameter int SCAN_W    = 16
) (
    input logic clk,
    input logic rst,
    polar_extract_seq_if.slave bus
);
    localparam int N_MAX = 1 << LOG_N_MAX;
    localparam int CW    = LOG_N_MAX + 1;
    localparam int KW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_XFORM   = 2'd1;
    localparam logic [1:0] S_EXTRACT = 2'd2;
    localparam logic [1:0] S_OUTPUT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N_MAX-1:0] x_q, x_d;
    logic [N_MAX-1:0] mask_q, mask_d;
    logic [3:0]       n_q, n_d;
    logic [CW-1:0]    stage_q, stage_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [K_MAX-1:0] pack_q, pack_d;
    logic             err_mode_q, err_mode_d;

    int               n_in;
    int               n_cur;
    int               stage_i;
    int               cnt_i;
    logic             clamp;
    logic [N_MAX-1:0] len_mask;
    logic [N_MAX-1:0] xs;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        mask_d     = mask_q;
        n_d        = n_q;
        stage_d    = stage_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        pack_d     = pack_q;
        err_mode_d = err_mode_q;
        xs         = x_q;
        cnt_i      = int'(cnt_q);
        stage_i    = int'(stage_q);
        n_cur      = int'(n_q);
        len_mask   = '0;

        n_in  = int'(bus.n_log);
        clamp = (n_in == 0) || (n_in > LOG_N_MAX);
        if (clamp) n_in = LOG_N_MAX;
        for (int i = 0; i < N_MAX; i++) len_mask[i] = (i < (1 << n_in));

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d        = bus.din & len_mask;
                    mask_d     = bus.info_mask & len_mask;
                    n_d        = n_in[3:0];
                    err_mode_d = clamp;
                    stage_d    = '0;
                    ptr_d      = '0;
                    cnt_d      = '0;
                    pack_d     = '0;
                    state_d    = S_XFORM;
                end
            end
            S_XFORM: begin
                // Stages commute, so in-place ascending order is safe: x[j-2^s] is never written in stage s.
                for (int st = 0; st < LOG_N_MAX; st++) begin
                    if (st >= stage_i && st < stage_i + SPC && st < n_cur) begin
                        for (int j = (1 << st); j < N_MAX; j++) begin
                            if (((j >> st) & 1) == 1) xs[j] = xs[j] ^ xs[j - (1 << st)];
                        end
                    end
                end
                x_d     = xs;
                stage_d = CW'(stage_i + SPC);
                if (stage_i + SPC >= n_cur) state_d = S_EXTRACT;
            end
            S_EXTRACT: begin
                for (int k = 0; k < SCAN_W; k++) begin
                    if (mask_q[k]) begin
                        if (cnt_i < K_MAX) pack_d[cnt_i[KW-1:0]] = x_q[k];
                        cnt_i = cnt_i + 1;
                    end
                end
                x_d    = x_q >> SCAN_W;
                mask_d = mask_q >> SCAN_W;
                cnt_d  = CW'(cnt_i);
                ptr_d  = CW'(int'(ptr_q) + SCAN_W);
                if (int'(ptr_q) + SCAN_W >= (1 << n_cur)) state_d = S_OUTPUT;
            end
            default: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            mask_q     <= '0;
            n_q        <= '0;
            stage_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            pack_q     <= '0;
            err_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            mask_q     <= mask_d;
            n_q        <= n_d;
            stage_q    <= stage_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            pack_q     <= pack_d;
            err_mode_q <= err_mode_d;
        end
    end

    // Result fields read as zero outside OUTPUT so stale frames never leak.
    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = (state_q == S_OUTPUT);
    assign bus.dout         = bus.out_valid ? pack_q : '0;
    assign bus.dout_cnt     = bus.out_valid ? cnt_q : '0;
    assign bus.err_overflow = bus.out_valid && (int'(cnt_q) > K_MAX);
    assign bus.err_mode     = bus.out_valid && err_mode_q;
endmodule

// File: tb/tb_polar_extract_seq.sv
// Directed + random frames for polar_extract_seq, checked against a subset-rule
// polar transform model with ascending-index compaction.
module tb_polar_extract_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    polar_extract_seq_if bus ();
    polar_extract_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // x[j] = XOR of u[i] for every i whose set bits are a subset of j's.
    function automatic void model(input logic [255:0] u, input logic [255:0] m, input int n,
                                  output logic [127:0] d, output int cnt);
        int len;
        logic [255:0] x;
        logic b;
        len = 1 << n;
        x = '0;
        for (int j = 0; j < len; j++) begin
            b = 1'b0;
            for (int i = 0; i < len; i++) if ((i & ~j) == 0) b = b ^ u[i];
            x[j] = b;
        end
        d = '0;
        cnt = 0;
        for (int j = 0; j < len; j++) begin
            if (m[j]) begin
                if (cnt < 128) d[cnt] = x[j];
                cnt++;
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge of cycle T+1.
    task automatic apply_stimulus(input string tag, input logic [255:0] u, input logic [255:0] m,
                                  input logic [3:0] nl);
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 256'(bus.in_ready), 256'(1));
        bus.din       = u;
        bus.info_mask = m;
        bus.n_log     = nl;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [127:0] exp_d, input int exp_cnt,
                                input logic emode);
        check({tag, "_out_valid"}, 256'(bus.out_valid), 256'(1));
        check({tag, "_dout"}, 256'(bus.dout), 256'(exp_d));
        check({tag, "_dout_cnt"}, 256'(bus.dout_cnt), 256'(exp_cnt));
        check({tag, "_err_overflow"}, 256'(bus.err_overflow), 256'(exp_cnt > 128));
        check({tag, "_err_mode"}, 256'(bus.err_mode), 256'(emode));
    endtask

    task automatic wait_output(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_frame(input string tag, input logic [255:0] u, input logic [255:0] m,
                             input logic [3:0] nl);
        int n, exp_lat, lat, exp_cnt;
        logic [127:0] exp_d;
        logic emode;
        emode = (nl == 0) || (nl > 8);
        n = emode ? 8 : int'(nl);
        model(u, m, n, exp_d, exp_cnt);
        exp_lat = 1 + (n + 1) / 2 + ((((1 << n) / 16) > 1) ? (1 << n) / 16 : 1);
        apply_stimulus(tag, u, m, nl);
        wait_output(lat);
        check({tag, "_latency"}, 256'(lat), 256'(exp_lat));
        check_output(tag, exp_d, exp_cnt, emode);
        @(negedge clk);
        check({tag, "_out_valid_drop"}, 256'(bus.out_valid), 256'(0));
    endtask

    initial begin
        logic [255:0] u, m;
        logic [127:0] exp_d;
        int exp_cnt, lat;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.din = '0;
        bus.info_mask = '0;
        bus.n_log = 4'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 256'(bus.in_ready), 256'(1));
        check("reset_out_valid", 256'(bus.out_valid), 256'(0));
        check("reset_dout", 256'(bus.dout), 256'(0));
        check("reset_dout_cnt", 256'(bus.dout_cnt), 256'(0));
        check("reset_errs", 256'({bus.err_overflow, bus.err_mode}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_frame("u0_only", 256'h1, {128'h0, {128{1'b1}}}, 4'd8);
        run_frame("top_bit", 256'h1 << 255, (256'h1 << 255) | 256'h8, 4'd8);
        run_frame("n2", {1'b1, 253'h0, 2'b11}, 256'hF, 4'd2);
        run_frame("overflow", rand256(), {256{1'b1}}, 4'd8);
        run_frame("nlog0", rand256(), rand256(), 4'd0);
        run_frame("nlog12", rand256(), rand256(), 4'd12);

        // Backpressure: result must hold while in_valid pulses are ignored.
        u = rand256();
        m = rand256();
        model(u, m, 8, exp_d, exp_cnt);
        bus.out_ready = 1'b0;
        apply_stimulus("bp", u, m, 4'd8);
        wait_output(lat);
        check("bp_latency", 256'(lat), 256'(21));
        bus.din = rand256();
        bus.info_mask = rand256();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            @(negedge clk);
            check("bp_in_ready", 256'(bus.in_ready), 256'(0));
            check_output("bp_hold", exp_d, exp_cnt, 1'b0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_idle", 256'({bus.in_ready, bus.out_valid}), 256'(2));
        run_frame("bp_next", rand256(), rand256(), 4'd5);

        // Reset during XFORM aborts the frame immediately.
        apply_stimulus("abort", rand256(), rand256(), 4'd8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 256'(bus.in_ready), 256'(1));
        check("abort_out_valid", 256'(bus.out_valid), 256'(0));
        check("abort_dout", 256'({bus.dout, bus.dout_cnt}), 256'(0));
        check("abort_errs", 256'({bus.err_overflow, bus.err_mode}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_abort", rand256(), rand256(), 4'd8);

        for (int r = 0; r < 8; r++) begin
            run_frame($sformatf("rand%0d", r), rand256(), rand256(), 4'($urandom_range(1, 8)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/polar_extract_seq.md
Name: polar_extract_seq

Overview:
- Parametrised, sequential successor to the fixed 256-bit combinational polar re-encode/extract block.
- Accepts one frame of N = 2^n_log bits (runtime n_log) and applies the polar transform x = u·F^{⊗n} as iterative butterfly stages.
- Compacts the bits selected by a runtime information-set mask into a packed K_MAX-bit result, returned over a valid/ready handshake.
- Sits between the SC decoder output and the CRC/payload sink.

Parameters:
- LOG_N_MAX, 8, log2 of maximum code length; N_MAX = 2^LOG_N_MAX.
- K_MAX, 128, width of packed output; maximum information bits delivered.
- SPC, 2, butterfly stages executed per clock (1..LOG_N_MAX).
- SCAN_W, 16, mask positions examined per clock during extraction; must divide N_MAX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  frame available.
- in_ready  out  1  block can accept a frame.
- din  in  N_MAX  u vector; bit i = u_i. Bits at index >= N are ignored.
- n_log  in  4  code length exponent, sampled at input handshake.
- info_mask  in  N_MAX  1 = information position; bits at index >= N are ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- dout  out  K_MAX  packed info bits; lowest selected index in bit 0. Unused upper bits are 0.
- dout_cnt  out  LOG_N_MAX+1  number of selected positions (popcount of the mask within N).
- err_overflow  out  1  dout_cnt > K_MAX; excess bits are dropped.
- err_mode  out  1  n_log was out of range and was clamped.

Behaviour:
- Reset (asynchronous): state=IDLE. in_ready=1. out_valid=0, dout=0, dout_cnt=0, err_overflow=0, err_mode=0. Work registers cleared.
- Reset asserted mid-frame aborts the frame. No output is produced for it.
- States: IDLE -> XFORM -> EXTRACT -> OUTPUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (cycle T), latch din, info_mask and n_log, then go to XFORM.
  - If n_log == 0 or n_log > LOG_N_MAX, use LOG_N_MAX and set err_mode for this frame.
  - Latched din/mask bits at index >= N are zeroed.
- XFORM:
  - Stage s (0..n-1) updates x[j] ^= x[j - 2^s] for every j < N with bit s of j set.
  - Each stage uses values from the previous stage.
  - SPC stages complete per cycle. The last cycle may contain fewer stages.
  - Result: x[j] = XOR of u[i] over all i whose bit set is a subset of j's.
  - Duration is ceil(n/SPC) cycles.
- EXTRACT:
  - Scan pointer p starts at 0. Each cycle examines positions p..p+SCAN_W-1 in ascending order.
  - Each position with mask=1 appends x[idx] at packed position cnt, then cnt increments.
  - Writes at cnt >= K_MAX are suppressed, but cnt still counts.
  - Duration is N/SCAN_W cycles, with a minimum of 1; for N < SCAN_W a single cycle covers positions 0..N-1.
  - Then go to OUTPUT.
- OUTPUT:
  - out_valid=1. dout, dout_cnt, err_overflow and err_mode are held stable until out_valid&out_ready.
  - On that handshake, go to IDLE and deassert out_valid the next cycle.
- Timing:
  - in_ready=0 in every state except IDLE; in_valid is ignored there.
  - out_valid rises at cycle T+1+ceil(n/SPC)+max(1,N/SCAN_W).
  - With default parameters and n=8, that is T+21.
  - Back-to-back frame throughput is one frame per (that latency + 1) cycles.
- Errors:
  - err_overflow = (dout_cnt > K_MAX).
  - Both error flags are valid only while out_valid=1 and are cleared on return to IDLE.
- Widths: dout_cnt saturates at no value; its range is 0..N_MAX.

Test Plan:
- n_log=8, din=1 (u0 only), info_mask low 128 bits=1 -> x all ones; dout=all 128 ones, dout_cnt=128, errors 0, out_valid at T+21.
- n_log=8, din=1<<255, info_mask bits {3,255} -> dout=0b10, dout_cnt=2.
- n_log=2, din=4'b0011 with din[255]=1 (ignored), info_mask=4'b1111 -> x=4'b0101; dout=0x5, dout_cnt=4, out_valid at T+3.
- n_log=8, info_mask all ones, din=random -> dout_cnt=256, err_overflow=1, dout = x[127:0] matching a software model.
- Backpressure: hold out_ready=0 for 10 cycles while pulsing in_valid -> dout stable, in_ready=0, no new frame accepted; release -> IDLE, next frame accepted.
- n_log=0 -> treated as 8, err_mode=1. Separately, assert rst during XFORM -> all outputs at reset values immediately; the next frame completes correctly.
